apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Single-outstanding APB master. Converts a valid/ready command interface into legal APB
//  SETUP/ACCESS sequences (PSEL, PENABLE, PADDR, PWRITE, PWDATA) that drive apb_top.
//  Returns PRDATA/PSLVERR on a valid/ready response interface.
//  Sits directly upstream of apb_top; a PREADY timeout guards against a hung slave.
// PARAMETERS
//  ADDR_WIDTH  32  width of cmd_addr / PADDR
//  DATA_WIDTH  32  width of cmd_wdata, rsp_rdata, PWDATA, PRDATA
//  TIMEOUT     16  max consecutive ACCESS cycles with PREADY=0 before abort; 0 = never abort
// PORTS
//  PCLK       in   1           single clock, all logic on rising edge
//  PRESETn    in   1           synchronous, active-low reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           bridge can accept a command (high only in IDLE)
//  cmd_write  in   1           1 = write, 0 = read
//  cmd_addr   in   ADDR_WIDTH  transfer address
//  cmd_wdata  in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           consumer accepts response
//  rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
//  rsp_err    out  1           PSLVERR captured, or timeout abort
//  PADDR      out  ADDR_WIDTH  APB address
//  PWRITE     out  1           APB direction
//  PWDATA     out  DATA_WIDTH  APB write data
//  PSEL       out  1           APB select
//  PENABLE    out  1           APB enable
//  PRDATA     in   DATA_WIDTH  APB read data
//  PREADY     in   1           APB ready
//  PSLVERR    in   1           APB slave error
// BEHAVIOUR
//  Reset: on any PCLK edge with PRESETn=0 -> state IDLE.
//   - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, wait counter all = 0.
//   - cmd_ready = (state==IDLE) & PRESETn, so it reads 1 the first cycle after reset.
//   - Mid-transfer reset aborts the transfer and drops the command; no response is produced.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB outputs are registered.
//  IDLE: cmd_valid&cmd_ready at edge N latches addr/write/wdata into PADDR/PWRITE/PWDATA.
//   Goes to SETUP with PSEL=1, PENABLE=0.
//  SETUP: next edge unconditionally -> ACCESS with PENABLE=1 and wait counter cleared.
//  ACCESS, PREADY=1 at edge:
//   - PSEL=PENABLE=0.
//   - rsp_err<=PSLVERR; rsp_rdata<=PRDATA for reads, 0 for writes.
//   - rsp_valid<=1 -> RESP.
//  ACCESS, PREADY=0:
//   - counter increments.
//   - If TIMEOUT!=0 and counter reaches TIMEOUT-1 while PREADY=0, abort at that edge:
//     PSEL=PENABLE=0, rsp_err=1, rsp_rdata=0, rsp_valid=1 -> RESP.
//   - So an abort occurs after exactly TIMEOUT ACCESS cycles.
//  PREADY/PSLVERR/PRDATA are ignored outside ACCESS. PSLVERR is only sampled with PREADY=1.
//  PADDR/PWRITE/PWDATA stay stable from SETUP through ACCESS and hold their value afterwards.
//  RESP: rsp_valid, rsp_rdata, rsp_err are held stable until rsp_ready=1 at an edge.
//   Then rsp_valid=0 -> IDLE. cmd_ready stays 0 throughout RESP.
//  Latency, zero-wait slave: accept edge N; PSEL high after N; PENABLE high after N+1;
//   rsp_valid high after N+2. Min issue interval 4 cycles with rsp_ready tied high.
//  PENABLE is never high without PSEL. PSEL always precedes PENABLE by exactly 1 cycle.
// TESTING
//  1. Write 0x1234_5678 to 0x0000_1000, PREADY=1 -> PSEL 2 cycles, PENABLE 1 cycle (2nd),
//     rsp_valid with rsp_err=0, rsp_rdata=0.
//  2. Read 0x0000_1000 from apb_top after test 1 -> rsp_rdata=0x1234_5678, rsp_err=0.
//  3. Read with PREADY low 3 ACCESS cycles -> PENABLE high 4 cycles;
//     PADDR/PWRITE stable throughout; rsp 1 cycle after PREADY.
//  4. Write with PREADY=1, PSLVERR=1 -> rsp_err=1. PSLVERR=1 while PREADY=0 -> no effect.
//  5. PREADY stuck 0, TIMEOUT=16 -> PENABLE high exactly 16 cycles, then rsp_err=1,
//     rsp_rdata=0. TIMEOUT=0 -> waits indefinitely.
//  6. rsp_ready low 5 cycles -> rsp_valid/data held, cmd_ready=0.
//     PRESETn low 1 cycle in ACCESS -> all outputs 0 next edge, no response, next cmd OK.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB master signals for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is its environment.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns one valid/ready command into a SETUP/ACCESS
// sequence and returns PRDATA/PSLVERR (or a PREADY timeout abort) as a response.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                PCLK,
    input logic                PRESETn,
    apb_master_bridge_if.master bus
);
    localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  timeout_hit;

    // Last permitted ACCESS cycle reached (never true when the timeout is disabled).
    assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == CNT_W'(CNT_LAST));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // A completing slave wins over a timeout on the same edge.
                if (bus.PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE) & PRESETn;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed table, hand sequences and randomized
// transactions against an APB slave model and a transaction-level reference.
module tb_apb_master_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b  ();
    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(clk), .PRESETn(rst_n), .bus(b)
    );
    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .bus(b0)
    );

    always #5 clk = ~clk;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_pen;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], 16'h5A5A};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic slave_noise();
        b.PREADY  = 1'($urandom);
        b.PSLVERR = 1'($urandom);
        b.PRDATA  = $urandom;
    endtask

    // One full command/response transaction; the slave model answers after 'waits' ACCESS cycles.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic err,
                           input int stall, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_pen);
        int guard;
        int cyc;
        int psel_n;
        int pen_n;
        guard = 0;
        while (!b.cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        check({tag, " cmd_ready"}, 64'(b.cmd_ready), 64'(1));
        b.cmd_valid = 1'b1;
        b.cmd_write = wr;
        b.cmd_addr  = addr;
        b.cmd_wdata = wdata;
        b.rsp_ready = 1'b0;
        slave_noise();
        step();
        b.cmd_valid = 1'b0;
        b.cmd_write = 1'($urandom);
        b.cmd_addr  = $urandom;
        b.cmd_wdata = $urandom;
        cyc = 0;
        psel_n = 0;
        pen_n = 0;
        while (!b.rsp_valid && cyc < 100) begin
            check({tag, " phase"}, 64'({b.PSEL, b.PENABLE}), (cyc == 0) ? 64'(2'b10) : 64'(2'b11));
            check({tag, " paddr"}, 64'(b.PADDR), 64'(addr));
            check({tag, " pwrite"}, 64'(b.PWRITE), 64'(wr));
            check({tag, " pwdata"}, 64'(b.PWDATA), 64'(wdata));
            check({tag, " cmd_ready_busy"}, 64'(b.cmd_ready), 64'(0));
            if (b.PSEL) psel_n++;
            if (b.PENABLE) begin
                if (pen_n == waits) begin
                    b.PREADY  = 1'b1;
                    b.PSLVERR = err;
                    if (b.PWRITE) begin
                        b.PRDATA = $urandom;
                        if (!err) slave_mem[b.PADDR] = b.PWDATA;
                    end else begin
                        b.PRDATA = slave_mem.exists(b.PADDR) ? slave_mem[b.PADDR] : dflt(b.PADDR);
                    end
                end else begin
                    b.PREADY  = 1'b0;
                    b.PSLVERR = 1'($urandom);
                    b.PRDATA  = $urandom;
                end
                pen_n++;
            end else begin
                slave_noise();
            end
            step();
            cyc++;
        end
        check({tag, " rsp_valid"}, 64'(b.rsp_valid), 64'(1));
        check({tag, " rsp_rdata"}, 64'(b.rsp_rdata), 64'(exp_rdata));
        check({tag, " rsp_err"}, 64'(b.rsp_err), 64'(exp_err));
        check({tag, " penable_cycles"}, 64'(pen_n), 64'(exp_pen));
        check({tag, " psel_cycles"}, 64'(psel_n), 64'(exp_pen + 1));
        check({tag, " apb_idle"}, 64'({b.PSEL, b.PENABLE}), 64'(0));
        for (int s = 0; s < stall; s++) begin
            slave_noise();
            step();
            check({tag, " hold_valid"}, 64'(b.rsp_valid), 64'(1));
            check({tag, " hold_rdata"}, 64'(b.rsp_rdata), 64'(exp_rdata));
            check({tag, " hold_err"}, 64'(b.rsp_err), 64'(exp_err));
            check({tag, " hold_cmd_ready"}, 64'(b.cmd_ready), 64'(0));
            check({tag, " hold_psel"}, 64'({b.PSEL, b.PENABLE}), 64'(0));
        end
        b.rsp_ready = 1'b1;
        step();
        b.rsp_ready = 1'b0;
        check({tag, " rsp_drop"}, 64'(b.rsp_valid), 64'(0));
        check({tag, " ready_again"}, 64'(b.cmd_ready), 64'(1));
        check({tag, " paddr_after"}, 64'(b.PADDR), 64'(addr));
    endtask

    // Transaction-level reference: result and ACCESS length from the command and slave behaviour.
    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic err, output logic [31:0] rd,
                         output logic rerr, output int pen);
        logic timed;
        timed = (waits >= int'(TO));
        pen   = timed ? int'(TO) : waits + 1;
        rerr  = timed ? 1'b1 : err;
        if (wr || timed) rd = 32'h0;
        else rd = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
        if (wr && !timed && !err) ref_mem[addr] = wdata;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rerr;
        int          pen;
        int          n;

        vecs[0] = '{1'b1, 32'h0000_1000, 32'h1234_5678,   0, 1'b0, 0, 32'h0000_0000, 1'b0,  1};
        vecs[1] = '{1'b0, 32'h0000_1000, 32'h0000_0000,   0, 1'b0, 0, 32'h1234_5678, 1'b0,  1};
        vecs[2] = '{1'b0, 32'h0000_1000, 32'h0000_0000,   3, 1'b0, 0, 32'h1234_5678, 1'b0,  4};
        vecs[3] = '{1'b1, 32'h0000_2000, 32'hDEAD_BEEF,   0, 1'b1, 0, 32'h0000_0000, 1'b1,  1};
        vecs[4] = '{1'b1, 32'h0000_2000, 32'hCAFE_F00D,   2, 1'b0, 0, 32'h0000_0000, 1'b0,  3};
        vecs[5] = '{1'b0, 32'h0000_2000, 32'h0000_0000,   0, 1'b0, 0, 32'hCAFE_F00D, 1'b0,  1};
        vecs[6] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 100, 1'b0, 0, 32'h0000_0000, 1'b1, 16};
        vecs[7] = '{1'b0, 32'h0000_1000, 32'h0000_0000,  15, 1'b0, 0, 32'h1234_5678, 1'b0, 16};
        vecs[8] = '{1'b1, 32'h0000_1000, 32'hFFFF_0000,  30, 1'b0, 0, 32'h0000_0000, 1'b1, 16};
        vecs[9] = '{1'b0, 32'h0000_1000, 32'h0000_0000,   1, 1'b0, 5, 32'h1234_5678, 1'b0,  2};

        rst_n = 1'b0;
        b.cmd_valid = 1'b0; b.cmd_write = 1'b0; b.cmd_addr = '0; b.cmd_wdata = '0;
        b.rsp_ready = 1'b0; b.PRDATA = '0; b.PREADY = 1'b0; b.PSLVERR = 1'b0;
        b0.cmd_valid = 1'b0; b0.cmd_write = 1'b0; b0.cmd_addr = '0; b0.cmd_wdata = '0;
        b0.rsp_ready = 1'b0; b0.PRDATA = '0; b0.PREADY = 1'b0; b0.PSLVERR = 1'b0;
        step();
        step();
        check("reset apb", 64'({b.PSEL, b.PENABLE, b.PWRITE}), 64'(0));
        check("reset paddr", 64'(b.PADDR), 64'(0));
        check("reset pwdata", 64'(b.PWDATA), 64'(0));
        check("reset rsp", 64'({b.rsp_valid, b.rsp_err}), 64'(0));
        check("reset rdata", 64'(b.rsp_rdata), 64'(0));
        check("reset cmd_ready_low", 64'(b.cmd_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        check("reset cmd_ready", 64'(b.cmd_ready), 64'(1));

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].waits, vecs[i].err, vecs[i].stall, vecs[i].exp_rdata,
                    vecs[i].exp_err, vecs[i].exp_pen);
            model(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].err, rd, rerr, pen);
        end

        // Reset in the middle of an ACCESS phase.
        b.cmd_valid = 1'b1; b.cmd_write = 1'b1; b.cmd_addr = 32'h0000_3000; b.cmd_wdata = 32'h7777_7777;
        b.PREADY = 1'b0;
        step();
        b.cmd_valid = 1'b0;
        step();
        check("midrst in_access", 64'(b.PENABLE), 64'(1));
        step();
        rst_n = 1'b0;
        step();
        check("midrst apb", 64'({b.PSEL, b.PENABLE, b.PWRITE}), 64'(0));
        check("midrst paddr", 64'(b.PADDR), 64'(0));
        check("midrst pwdata", 64'(b.PWDATA), 64'(0));
        check("midrst rsp", 64'({b.rsp_valid, b.rsp_err}), 64'(0));
        check("midrst rdata", 64'(b.rsp_rdata), 64'(0));
        check("midrst cmd_ready_low", 64'(b.cmd_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        check("midrst cmd_ready", 64'(b.cmd_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            b.PREADY = 1'b1;
            step();
            check("midrst no_rsp", 64'({b.rsp_valid, b.PSEL}), 64'(0));
        end
        model(1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, rd, rerr, pen);
        run_txn("post_rst", 1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, 0, rd, rerr, pen);

        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          waits;
            logic        err;
            int          stall;
            wr    = 1'($urandom);
            addr  = 32'($urandom_range(0, 15)) << 2;
            wdata = $urandom;
            waits = int'($urandom_range(0, 20));
            err   = ($urandom_range(0, 3) == 0);
            stall = int'($urandom_range(0, 3));
            model(wr, addr, wdata, waits, err, rd, rerr, pen);
            run_txn($sformatf("rnd%0d", t), wr, addr, wdata, waits, err, stall, rd, rerr, pen);
        end

        // TIMEOUT=0 instance must wait indefinitely for PREADY.
        b0.cmd_valid = 1'b1; b0.cmd_write = 1'b0; b0.cmd_addr = 32'h0000_0040;
        b0.PREADY = 1'b0;
        step();
        b0.cmd_valid = 1'b0;
        step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (b0.PENABLE && !b0.rsp_valid) n++;
            b0.PREADY = 1'b0;
            step();
        end
        check("notimeout waiting", 64'(n), 64'(40));
        check("notimeout still_access", 64'({b0.PSEL, b0.PENABLE, b0.rsp_valid}), 64'(3'b110));
        b0.PREADY = 1'b1;
        b0.PRDATA = 32'h0BAD_F00D;
        b0.PSLVERR = 1'b0;
        step();
        b0.PREADY = 1'b0;
        check("notimeout rsp_valid", 64'(b0.rsp_valid), 64'(1));
        check("notimeout rdata", 64'(b0.rsp_rdata), 64'(32'h0BAD_F00D));
        check("notimeout err", 64'(b0.rsp_err), 64'(0));
        b0.rsp_ready = 1'b1;
        step();
        check("notimeout drop", 64'(b0.rsp_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
